// File: rtl/fft_frame_buf_ctrl.sv
// Frame sequencer for a 2**ADDR_W-entry dual-port sample RAM: fills it via port A, then replays
// it via port B through a 2-entry skid buffer. Define BITREV_EN for bit-reversed replay order.
module fft_frame_buf_ctrl #(
  parameter int WIDTH  = 11,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic              frame_done,
  output logic              ram_en_a,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [WIDTH-1:0]  ram_di_a,
  output logic              ram_en_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  input  logic [WIDTH-1:0]  ram_do_b
);

  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [ADDR_W:0]  wr_cnt, rd_cnt, out_cnt;
  logic [1:0]       occ, level_nxt;
  logic             in_flight, in_hs, out_hs, rd_issue, push_slot;
  logic [WIDTH-1:0] skid [2];

  function automatic logic [ADDR_W-1:0] rd_addr(input logic [ADDR_W-1:0] idx);
    logic [ADDR_W-1:0] r;
`ifdef BITREV_EN
    r = '0;
    for (int i = 0; i < ADDR_W; i++) r[i] = idx[ADDR_W-1-i];
`else
    r = idx;
`endif
    return r;
  endfunction

  assign out_valid  = (occ != 2'd0);
  assign out_data   = skid[0];
  assign out_last   = out_valid && (out_cnt == LAST_IDX);
  assign out_hs     = out_valid && out_ready;
  // Skid fill level next cycle: the in-flight read lands, the popped head leaves.
  assign level_nxt  = occ + {1'b0, in_flight} - {1'b0, out_hs};
  // Slot the landing read is written to after any pop shift (low bit of occ - pop).
  assign push_slot  = occ[0] ^ out_hs;
  assign in_hs      = ram_we_a;
  assign rd_issue   = ram_en_b;
  assign ram_en_a   = ram_we_a;
  assign ram_addr_a = wr_cnt[ADDR_W-1:0];
  assign ram_di_a   = in_data;
  assign ram_addr_b = rd_addr(rd_cnt[ADDR_W-1:0]);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    ram_we_a   = 1'b0;
    ram_en_b   = 1'b0;
    frame_done = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        ram_we_a = in_valid;
        if (in_valid && (wr_cnt == LAST_IDX)) state_nxt = DRAIN;
      end
      DRAIN: begin
        ram_en_b   = !rd_cnt[ADDR_W] && (level_nxt < 2'd2);
        frame_done = out_hs && out_last;
        if (frame_done) state_nxt = FILL;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      out_cnt   <= '0;
      occ       <= '0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= rd_issue;
      occ       <= level_nxt;
      if (in_hs)    wr_cnt  <= (wr_cnt == LAST_IDX) ? '0 : wr_cnt + ONE;
      if (rd_issue) rd_cnt  <= rd_cnt + ONE;
      if (out_hs)   out_cnt <= out_cnt + ONE;
      if (frame_done) begin
        wr_cnt  <= '0;
        rd_cnt  <= '0;
        out_cnt <= '0;
      end
    end
  end

  // NOTE: skid data has no reset; occ alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (out_hs)    skid[0]         <= skid[1];
    if (in_flight) skid[push_slot] <= ram_do_b;
  end

endmodule

// File: tb/tb_fft_frame_buf_ctrl.sv
// Directed bench for fft_frame_buf_ctrl with a registered-read dual-port RAM model.
// Expected replay order follows BITREV_EN the same way the design build does.
module tb_fft_frame_buf_ctrl;
  localparam int WIDTH  = 11;
  localparam int ADDR_W = 6;
  localparam int N      = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid, out_ready, out_last, frame_done;
  logic [WIDTH-1:0]  out_data;
  logic              ram_en_a, ram_we_a, ram_en_b;
  logic [ADDR_W-1:0] ram_addr_a, ram_addr_b;
  logic [WIDTH-1:0]  ram_di_a, ram_do_b;
  logic [WIDTH-1:0]  mem [N];

  int n_pass = 0, n_total = 0, cyc = 0;

  fft_frame_buf_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frame_done(frame_done),
    .ram_en_a(ram_en_a), .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_di_a(ram_di_a),
    .ram_en_b(ram_en_b), .ram_addr_b(ram_addr_b), .ram_do_b(ram_do_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_en_a && ram_we_a) mem[ram_addr_a] <= ram_di_a;
    if (ram_en_b) ram_do_b <= mem[ram_addr_b];
  end

  // Results of the most recent send/drain.
  logic [WIDTH-1:0] got [$];
  int sent, last_in_cyc, first_valid_cyc, first_out_cyc, last_out_cyc;
  int done_idx, last_cnt, last_idx, unstable, busy_viol;
  logic ready_after, done_after;

  function automatic int exp_idx(input int k);
`ifdef BITREV_EN
    int r = 0;
    for (int b = 0; b < ADDR_W; b++) if (k[b]) r |= (1 << (ADDR_W - 1 - b));
    return r;
`else
    return k;
`endif
  endfunction

  function automatic int order_errors(input int base);
    int bad = 0;
    logic [WIDTH-1:0] e;
    for (int i = 0; i < N; i++) begin
      e = WIDTH'(base + exp_idx(i));
      if (i >= got.size()) bad++;
      else if (got[i] !== e) bad++;
    end
    return bad;
  endfunction

  task automatic send_samples(input int base, input int count, input bit gaps);
    int k = 0, guard = 0;
    while (k < count && guard < 4 * count + 20) begin
      @(negedge clk);
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = WIDTH'(base + k);
      #1;
      if (in_valid && in_ready) begin
        last_in_cyc = cyc;
        k++;
      end
      guard++;
    end
    sent = k;
  endtask

  task automatic drain_frame(input bit bp, input bit hold_in);
    logic prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    bit done = 1'b0;
    int guard = 0;
    got.delete();
    first_valid_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
    done_idx = -1; last_cnt = 0; last_idx = -1; unstable = 0; busy_viol = 0;
    while (!done && guard < 2000) begin
      @(negedge clk);
      in_valid  = hold_in;
      in_data   = '1;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (in_ready || ram_we_a) busy_viol++;
      if (prev_stall && (!out_valid || out_data !== prev_data)) unstable++;
      if (out_last && !out_valid) last_cnt++;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        if (out_last) begin
          last_cnt++;
          last_idx = got.size();
        end
      end
      if (frame_done) begin
        done_idx = got.size();
        done = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      guard++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    ready_after = in_ready;
    done_after  = frame_done;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_total++; if (in_ready !== 1'b1)   $display("FAIL reset in_ready: got %b want 1", in_ready);     else n_pass++;
    n_total++; if (out_valid !== 1'b0)  $display("FAIL reset out_valid: got %b want 0", out_valid);   else n_pass++;
    n_total++; if (out_last !== 1'b0)   $display("FAIL reset out_last: got %b want 0", out_last);     else n_pass++;
    n_total++; if (frame_done !== 1'b0) $display("FAIL reset frame_done: got %b want 0", frame_done); else n_pass++;
    n_total++; if (ram_en_b !== 1'b0)   $display("FAIL reset ram_en_b: got %b want 0", ram_en_b);     else n_pass++;
    n_total++; if (ram_we_a !== 1'b0)   $display("FAIL reset ram_we_a: got %b want 0", ram_we_a);     else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_frame();
    int bad;
    send_samples(0, N, 1'b0);
    drain_frame(1'b0, 1'b0);
    bad = order_errors(0);
    n_total++; if (sent !== N)        $display("FAIL frame sent: got %0d want %0d", sent, N);           else n_pass++;
    n_total++; if (got.size() !== N)  $display("FAIL frame count: got %0d want %0d", got.size(), N);    else n_pass++;
    n_total++; if (bad !== 0)         $display("FAIL frame order: got %0d bad samples want 0", bad);    else n_pass++;
    n_total++; if (last_cnt !== 1)    $display("FAIL frame last count: got %0d want 1", last_cnt);      else n_pass++;
    n_total++; if (last_idx !== N)    $display("FAIL frame last pos: got %0d want %0d", last_idx, N);   else n_pass++;
    n_total++; if (done_idx !== N)    $display("FAIL frame done pos: got %0d want %0d", done_idx, N);   else n_pass++;
    n_total++; if (done_after !== 1'b0) $display("FAIL frame done width: got %b want 0", done_after);   else n_pass++;
    n_total++; if (first_valid_cyc - last_in_cyc !== 3)
      $display("FAIL frame latency: got %0d want 3", first_valid_cyc - last_in_cyc); else n_pass++;
    n_total++; if (last_out_cyc - first_out_cyc !== N - 1)
      $display("FAIL frame throughput: got %0d want %0d", last_out_cyc - first_out_cyc, N - 1); else n_pass++;
    n_total++; if (ready_after !== 1'b1) $display("FAIL frame ready after done: got %b want 1", ready_after); else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad;
    send_samples(600, N, 1'b0);
    drain_frame(1'b1, 1'b0);
    bad = order_errors(600);
    n_total++; if (got.size() !== N) $display("FAIL bp count: got %0d want %0d", got.size(), N); else n_pass++;
    n_total++; if (bad !== 0)        $display("FAIL bp order: got %0d bad samples want 0", bad); else n_pass++;
    n_total++; if (unstable !== 0)   $display("FAIL bp stall stability: got %0d changes want 0", unstable); else n_pass++;
    n_total++; if (last_idx !== N)   $display("FAIL bp last pos: got %0d want %0d", last_idx, N); else n_pass++;
  endtask

  task automatic test_hold_valid();
    int bad;
    send_samples(400, N, 1'b0);
    drain_frame(1'b0, 1'b1);
    bad = order_errors(400);
    n_total++; if (busy_viol !== 0)      $display("FAIL hold busy: got %0d cycles with in_ready/we want 0", busy_viol); else n_pass++;
    n_total++; if (bad !== 0)            $display("FAIL hold order: got %0d bad samples want 0", bad); else n_pass++;
    n_total++; if (ready_after !== 1'b1) $display("FAIL hold ready after done: got %b want 1", ready_after); else n_pass++;
  endtask

  task automatic test_mid_reset();
    int bad;
    // Reset while the skid buffer holds samples.
    send_samples(300, N, 1'b0);
    repeat (6) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
    end
    #1;
    n_total++; if (out_valid !== 1'b1) $display("FAIL drain stall valid: got %b want 1", out_valid); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL drain reset out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1)  $display("FAIL drain reset in_ready: got %b want 1", in_ready);   else n_pass++;
    n_total++; if (ram_en_b !== 1'b0)  $display("FAIL drain reset ram_en_b: got %b want 0", ram_en_b);   else n_pass++;
    // Reset after a partial input frame.
    send_samples(50, 20, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL fill reset out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1)  $display("FAIL fill reset in_ready: got %b want 1", in_ready);   else n_pass++;
    send_samples(100, N, 1'b0);
    drain_frame(1'b0, 1'b0);
    bad = order_errors(100);
    n_total++; if (sent !== N)       $display("FAIL post reset sent: got %0d want %0d", sent, N); else n_pass++;
    n_total++; if (got.size() !== N) $display("FAIL post reset count: got %0d want %0d", got.size(), N); else n_pass++;
    n_total++; if (bad !== 0)        $display("FAIL post reset order: got %0d bad samples want 0", bad); else n_pass++;
  endtask

  task automatic test_two_frames();
    int bad;
    for (int f = 0; f < 2; f++) begin
      send_samples(200 + 300 * f, N, 1'b1);
      drain_frame(f[0], 1'b0);
      bad = order_errors(200 + 300 * f);
      n_total++; if (sent !== N)       $display("FAIL two frames %0d sent: got %0d want %0d", f, sent, N); else n_pass++;
      n_total++; if (got.size() !== N) $display("FAIL two frames %0d count: got %0d want %0d", f, got.size(), N); else n_pass++;
      n_total++; if (bad !== 0)        $display("FAIL two frames %0d order: got %0d bad samples want 0", f, bad); else n_pass++;
      n_total++; if (done_idx !== N)   $display("FAIL two frames %0d done pos: got %0d want %0d", f, done_idx, N); else n_pass++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_frame();
    test_backpressure();
    test_hold_valid();
    test_mid_reset();
    test_two_frames();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
